// File: rtl/booth_mult_seq_pkg.sv
// Shared types and helpers for the sequential radix-2 Booth multiplier.
// BOOTH_SIGNED_MODE_EN widens the internal datapath by one bit to support unsigned operands.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  // Booth decode of {Q[0], q_m1}
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

  // Internal operand width, which is also the iteration count.
  function automatic int unsigned booth_iter(input int unsigned width);
`ifdef BOOTH_SIGNED_MODE_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/booth_mult_seq_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M into A,
// then arithmetic shift right of {A, Q, q_m1}.
module booth_step
  import booth_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic [W:0]   a_i,
  input  logic [W-1:0] q_i,
  input  logic         qm1_i,
  input  logic [W-1:0] m_i,
  output logic [W:0]   a_o,
  output logic [W-1:0] q_o,
  output logic         qm1_o
);

  logic [W:0] m_sx;
  logic [W:0] sum;

  always_comb begin
    m_sx = {m_i[W-1], m_i};
    sum  = a_i;
    unique case ({q_i[0], qm1_i})
      BOOTH_ADD: sum = a_i + m_sx;
      BOOTH_SUB: sum = a_i - m_sx;
      default:   sum = a_i;
    endcase
    // Guard bit of A is replicated into the vacated MSB.
    {a_o, q_o, qm1_o} = {sum[W], sum, q_i};
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier with start/busy/done handshake.
// Optional macro BOOTH_SIGNED_MODE_EN adds signed_i and a one-bit-wider datapath.
import booth_pkg::*;

module booth_mult_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   multiplicand_i,
  input  logic [WIDTH-1:0]   multiplier_i,
`ifdef BOOTH_SIGNED_MODE_EN
  input  logic               signed_i,
`endif
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] result_o
);

  localparam int unsigned W     = booth_iter(WIDTH);
  localparam int unsigned ITER  = W;
  localparam int unsigned CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

  state_e               state_q, state_d;
  logic [W:0]           a_q, a_d;
  logic [W-1:0]         q_q, q_d;
  logic                 qm1_q, qm1_d;
  logic [W-1:0]         m_q, m_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   result_q, result_d;

  logic [W-1:0]         m_ext, q_ext;
  logic [W:0]           a_nxt;
  logic [W-1:0]         q_nxt;
  logic                 qm1_nxt;

  always_comb begin
`ifdef BOOTH_SIGNED_MODE_EN
    m_ext = signed_i ? {multiplicand_i[WIDTH-1], multiplicand_i} : {1'b0, multiplicand_i};
    q_ext = signed_i ? {multiplier_i[WIDTH-1], multiplier_i}     : {1'b0, multiplier_i};
`else
    m_ext = multiplicand_i;
    q_ext = multiplier_i;
`endif
  end

  booth_step #(
    .W(W)
  ) u_step (
    .a_i   (a_q),
    .q_i   (q_q),
    .qm1_i (qm1_q),
    .m_i   (m_q),
    .a_o   (a_nxt),
    .q_o   (q_nxt),
    .qm1_o (qm1_nxt)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    q_d      = q_q;
    qm1_d    = qm1_q;
    m_d      = m_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d = CALC;
          a_d     = '0;
          q_d     = q_ext;
          qm1_d   = 1'b0;
          m_d     = m_ext;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        a_d   = a_nxt;
        q_d   = q_nxt;
        qm1_d = qm1_nxt;
        cnt_d = cnt_q + CNT_W'(1);
        // Result is taken from the step output so it lands on the final edge.
        if (cnt_q == CNT_W'(ITER - 1)) begin
          state_d  = DONE;
          result_d = (2*WIDTH)'({a_nxt, q_nxt});
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      q_q      <= '0;
      qm1_q    <= 1'b0;
      m_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      q_q      <= q_d;
      qm1_q    <= qm1_d;
      m_q      <= m_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign busy_o   = (state_q == CALC);
  assign done_o   = (state_q == DONE);
  assign result_o = result_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq at WIDTH=4 and WIDTH=8 (honours BOOTH_SIGNED_MODE_EN).
module tb_booth_mult_seq;

`ifdef BOOTH_SIGNED_MODE_EN
  localparam int ITER4 = 5;
  localparam int ITER8 = 9;
`else
  localparam int ITER4 = 4;
  localparam int ITER8 = 8;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        st4 = 1'b0, sg4 = 1'b1;
  logic [3:0]  m4 = '0, q4 = '0;
  logic        busy4, done4;
  logic [7:0]  res4;

  logic        st8 = 1'b0, sg8 = 1'b1;
  logic [7:0]  m8 = '0, q8 = '0;
  logic        busy8, done8;
  logic [15:0] res8;

  logic [7:0]  exp4_q[$];
  logic [15:0] exp8_q[$];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  booth_mult_seq #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .start_i(st4), .multiplicand_i(m4), .multiplier_i(q4),
`ifdef BOOTH_SIGNED_MODE_EN
    .signed_i(sg4),
`endif
    .busy_o(busy4), .done_o(done4), .result_o(res4)
  );

  booth_mult_seq #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start_i(st8), .multiplicand_i(m8), .multiplier_i(q8),
`ifdef BOOTH_SIGNED_MODE_EN
    .signed_i(sg8),
`endif
    .busy_o(busy8), .done_o(done8), .result_o(res8)
  );

  function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b, input logic sgn);
    longint x;
    if (sgn) x = longint'($signed(a)) * longint'($signed(b));
    else     x = longint'(a) * longint'(b);
    return x[15:0];
  endfunction

  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic sgn,
                      input logic [7:0] expv, input string name);
    int n, busy_n;
    bit seen, overlap;
    logic [7:0] e;
    @(negedge clk);
    m4 = a; q4 = b; sg4 = sgn; st4 = 1'b1;
    exp4_q.push_back(expv);
    n = 0; busy_n = 0; seen = 0; overlap = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) st4 = 1'b0;
      if (busy4 && done4) overlap = 1;
      if (busy4) busy_n++;
      if (done4) seen = 1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s timeout: no done_o within %0d cycles, required done", name, n);
    end else begin
      e = exp4_q.pop_front();
      checks++;
      if (res4 !== e) begin
        failures++;
        $display("FAIL %s result: got %h required %h", name, res4, e);
      end
      checks++;
      if (n - 1 != ITER4) begin
        failures++;
        $display("FAIL %s latency: got %0d required %0d", name, n - 1, ITER4);
      end
      checks++;
      if (busy_n != ITER4) begin
        failures++;
        $display("FAIL %s busy cycles: got %0d required %0d", name, busy_n, ITER4);
      end
    end
    if (overlap) begin
      failures++;
      $display("FAIL %s busy_done_overlap: got 1 required 0", name);
    end
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sgn,
                      input logic [15:0] expv, input string name);
    int n;
    bit seen;
    logic [15:0] e;
    @(negedge clk);
    m8 = a; q8 = b; sg8 = sgn; st8 = 1'b1;
    exp8_q.push_back(expv);
    n = 0; seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) st8 = 1'b0;
      if (done8) seen = 1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s timeout: no done_o within %0d cycles, required done", name, n);
    end else begin
      e = exp8_q.pop_front();
      checks++;
      if (res8 !== e) begin
        failures++;
        $display("FAIL %s a=%h b=%h result: got %h required %h", name, a, b, res8, e);
      end
      checks++;
      if (n - 1 != ITER8) begin
        failures++;
        $display("FAIL %s latency: got %0d required %0d", name, n - 1, ITER8);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy4 !== 1'b0) begin failures++; $display("FAIL reset_busy4: got %b required 0", busy4); end
    checks++; if (done4 !== 1'b0) begin failures++; $display("FAIL reset_done4: got %b required 0", done4); end
    checks++; if (res4 !== 8'h00) begin failures++; $display("FAIL reset_res4: got %h required 00", res4); end
    checks++; if (busy8 !== 1'b0) begin failures++; $display("FAIL reset_busy8: got %b required 0", busy8); end
    checks++; if (done8 !== 1'b0) begin failures++; $display("FAIL reset_done8: got %b required 0", done8); end
    checks++; if (res8 !== 16'h0000) begin failures++; $display("FAIL reset_res8: got %h required 0000", res8); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_signed4();
    run4(4'd3, 4'd5, 1'b1, 8'h0F, "w4_3x5");
    run4(4'h8, 4'h8, 1'b1, 8'h40, "w4_m8xm8");
    run4(4'h7, 4'h8, 1'b1, 8'hC8, "w4_7xm8");
    run4(4'h0, 4'hF, 1'b1, 8'h00, "w4_0xm1");
  endtask

`ifdef BOOTH_SIGNED_MODE_EN
  task automatic test_unsigned_mode();
    run4(4'hF, 4'hF, 1'b0, 8'hE1, "w4_u15x15");
    run4(4'hF, 4'hF, 1'b1, 8'h01, "w4_sFxF");
    run8(8'hFF, 8'hFF, 1'b0, 16'hFE01, "w8_u255x255");
  endtask
`endif

  task automatic test_corners8();
    logic [7:0] c [5];
    c = '{8'h80, 8'hFF, 8'h00, 8'h01, 8'h7F};
    run8(8'h80, 8'h7F, 1'b1, 16'hC080, "w8_m128x127");
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        run8(c[i], c[j], 1'b1, model8(c[i], c[j], 1'b1), "w8_corner");
  endtask

  task automatic test_start_ignored();
    int n, extra;
    bit seen;
    logic [7:0] e;
    @(negedge clk);
    m4 = 4'd3; q4 = 4'd5; sg4 = 1'b1; st4 = 1'b1;
    exp4_q.push_back(8'h0F);
    n = 0; seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) st4 = 1'b0;
      if (n == 2) begin st4 = 1'b1; m4 = 4'h7; q4 = 4'h8; end
      if (n == 3) st4 = 1'b0;
      if (done4) seen = 1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL midcalc timeout: no done_o, required done");
    end else begin
      e = exp4_q.pop_front();
      checks++;
      if (res4 !== e) begin failures++; $display("FAIL midcalc result: got %h required %h", res4, e); end
      checks++;
      if (n - 1 != ITER4) begin failures++; $display("FAIL midcalc latency: got %0d required %0d", n - 1, ITER4); end
    end
    extra = 0;
    repeat (ITER4 + 3) begin
      @(negedge clk);
      if (done4) extra++;
    end
    checks++;
    if (extra != 0) begin failures++; $display("FAIL midcalc extra_done: got %0d required 0", extra); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ma [3];
    logic [7:0] qa [3];
    logic [15:0] e;
    int n, last, k;
    ma = '{8'h80, 8'h12, 8'hF3};
    qa = '{8'h80, 8'h34, 8'h7F};
    @(negedge clk);
    m8 = ma[0]; q8 = qa[0]; sg8 = 1'b1; st8 = 1'b1;
    exp8_q.push_back(model8(ma[0], qa[0], 1'b1));
    n = 0; last = 0; k = 0;
    while (k < 3 && n < 200) begin
      @(negedge clk);
      n++;
      if (done8) begin
        e = exp8_q.pop_front();
        checks++;
        if (res8 !== e) begin failures++; $display("FAIL b2b_%0d result: got %h required %h", k, res8, e); end
        checks++;
        if (n - last != ITER8 + 1) begin
          failures++;
          $display("FAIL b2b_%0d spacing: got %0d required %0d", k, n - last, ITER8 + 1);
        end
        last = n;
        k++;
        if (k < 3) begin
          m8 = ma[k]; q8 = qa[k];
          exp8_q.push_back(model8(ma[k], qa[k], 1'b1));
        end else begin
          st8 = 1'b0;
        end
      end
    end
    st8 = 1'b0;
    checks++;
    if (k != 3) begin failures++; $display("FAIL b2b timeout: got %0d completions required 3", k); end
  endtask

  task automatic test_reset_midcalc();
    int extra;
    @(negedge clk);
    m4 = 4'd7; q4 = 4'd7; sg4 = 1'b1; st4 = 1'b1;
    @(negedge clk);
    st4 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (busy4 !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b required 0", busy4); end
    checks++; if (done4 !== 1'b0) begin failures++; $display("FAIL rstmid_done: got %b required 0", done4); end
    checks++; if (res4 !== 8'h00) begin failures++; $display("FAIL rstmid_result: got %h required 00", res4); end
    @(negedge clk);
    rst = 1'b1;
    extra = 0;
    repeat (ITER4 + 3) begin
      @(negedge clk);
      if (done4 || busy4) extra++;
    end
    checks++;
    if (extra != 0) begin failures++; $display("FAIL rstmid_ghost: got %0d active cycles required 0", extra); end
    run4(4'hD, 4'd6, 1'b1, 8'hEE, "rstmid_restart");
  endtask

  initial begin
    test_reset();
    test_signed4();
`ifdef BOOTH_SIGNED_MODE_EN
    test_unsigned_mode();
`endif
    test_corners8();
    test_start_ignored();
    test_back_to_back();
    test_reset_midcalc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
